insn_encoder: RTL and testbench

RV32I(M) instruction encoder and instruction-memory loader, the write-side counterpart of the control unit's decoder. It accepts field-level instruction commands (opcode, funct3, funct7 bits, register indices, immediate) over a valid/ready handshake and checks them against the same legal set the control unit decodes. Legal commands are packed into 32-bit machine words, buffered in a small FIFO, and written sequentially into instruction memory. It sits between the bring-up/self-test sequencer and the instruction memory write port.

---
 rtl/insn_encoder.sv | 175 +++++++++++++++++
 tb/tb_insn_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder.sv
// insn_encoder: checks field-level RV32I(M) commands against the decoder's legal
// set, packs legal ones into 32-bit words, buffers them in a FIFO and streams
// them into instruction memory at sequential byte addresses.
// Optional feature macro: RV32M_EN (enables the M-extension R-type encodings).
module insn_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_vld,
  output logic              o_cmd_rdy,
  input  logic [6:0]        i_op,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7_5,
  input  logic              i_funct7_0,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_start_addr,
  output logic              o_imem_wren,
  input  logic              i_imem_rdy,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [7:0]        o_err_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

`ifdef RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  logic signed [31:0] imm_s;
  logic        fit_i, fit_b, fit_j;
  logic        ill, mis, rng, cmd_err;
  logic [1:0]  err_code;
  logic [31:0] word;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          empty, full, accept, push, pop;

  assign imm_s = i_imm;
  // B/J alignment is checked separately, so the odd upper bound is harmless here
  assign fit_i = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fit_b = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4095);
  assign fit_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048575);

  // Legality check and word packing, purely from the presented command
  always_comb begin
    word = 32'h0;
    ill  = 1'b0;
    mis  = 1'b0;
    rng  = 1'b0;
    case (i_op)
      OP_LOAD: begin
        ill  = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
        rng  = !fit_i;
        word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
      end
      OP_IMM: begin
        if (i_funct3[1:0] == 2'b01) begin
          ill  = (i_funct3 == 3'b001) && i_funct7_5;
          rng  = (i_imm[31:5] != 27'd0);
          word = {1'b0, i_funct7_5, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, i_op};
        end else begin
          rng  = !fit_i;
          word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
        end
      end
      OP_AUIPC, OP_LUI: begin
        mis  = (i_imm[11:0] != 12'd0);
        word = {i_imm[31:12], i_rd, i_op};
      end
      OP_STORE: begin
        ill  = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        rng  = !fit_i;
        word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
      end
      OP_REG: begin
        ill  = (i_funct7_5 && !((i_funct3 == 3'b000) || (i_funct3 == 3'b101))) ||
               (i_funct7_5 && i_funct7_0) || (i_funct7_0 && !M_EN);
        word = {1'b0, i_funct7_5, 4'b0, i_funct7_0, i_rs2, i_rs1, i_funct3, i_rd, i_op};
      end
      OP_BRANCH: begin
        ill  = (i_funct3[2:1] == 2'b01);
        mis  = i_imm[0];
        rng  = !fit_b;
        word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_op};
      end
      OP_JALR: begin
        ill  = (i_funct3 != 3'b000);
        rng  = !fit_i;
        word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
      end
      OP_JAL: begin
        mis  = i_imm[0];
        rng  = !fit_j;
        word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
      end
      default: ill = 1'b1;
    endcase
  end

  assign err_code = ill ? 2'b01 : (mis ? 2'b11 : (rng ? 2'b10 : 2'b00));
  assign cmd_err  = ill | mis | rng;

  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign o_cmd_rdy    = !full;
  assign o_imem_wren  = !empty;
  assign accept       = i_cmd_vld && o_cmd_rdy;
  assign push         = accept && !cmd_err;
  assign pop          = o_imem_wren && i_imem_rdy;
  assign o_imem_wdata = empty ? 32'h0 : mem[rd_ptr];

  // Word storage; contents are qualified by cnt so it needs no reset
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Write address: reloadable only while idle, advances one word per pop
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                  o_imem_addr <= '0;
    else if (i_addr_load && empty) o_imem_addr <= i_start_addr & ~(ADDR_W'(3));
    else if (pop)                 o_imem_addr <= o_imem_addr + ADDR_W'(4);
  end

  // Reject reporting: one-cycle pulse, sticky code, saturating count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
      o_err_cnt  <= 8'd0;
    end else begin
      o_err <= accept && cmd_err;
      if (accept && cmd_err) begin
        o_err_code <= err_code;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: hand-encoded words, error codes, FIFO
// backpressure, address wrap/load and reset mid-drain.
module tb_insn_encoder;
  logic        i_clk, i_reset, i_cmd_vld, o_cmd_rdy;
  logic [6:0]  i_op;
  logic [2:0]  i_funct3;
  logic        i_funct7_5, i_funct7_0;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;
  logic        i_addr_load;
  logic [11:0] i_start_addr;
  logic        o_imem_wren, i_imem_rdy;
  logic [11:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [7:0]  o_err_cnt;

  int          n_vec, n_err;
  logic [11:0] exp_addr;
  logic [7:0]  exp_cnt;

  localparam logic [6:0] LOAD = 7'b0000011, IMM = 7'b0010011, STORE = 7'b0100011;
  localparam logic [6:0] REG  = 7'b0110011, LUI = 7'b0110111, BR    = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  insn_encoder #(.FIFO_DEPTH(4), .ADDR_W(12)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_op(i_op), .i_funct3(i_funct3), .i_funct7_5(i_funct7_5), .i_funct7_0(i_funct7_0),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .i_addr_load(i_addr_load), .i_start_addr(i_start_addr),
    .o_imem_wren(o_imem_wren), .i_imem_rdy(i_imem_rdy), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_err(o_err), .o_err_code(o_err_code), .o_err_cnt(o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    i_op = op; i_funct3 = f3; i_funct7_5 = f75; i_funct7_0 = f70;
    i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int t;
    set_cmd(op, f3, f75, f70, rd, rs1, rs2, imm);
    i_cmd_vld = 1'b1;
    t = 0;
    while (!o_cmd_rdy && t < 20) begin
      @(posedge i_clk); @(negedge i_clk); t++;
    end
    if (!o_cmd_rdy) chk("send_rdy", 32'(o_cmd_rdy), 32'd1);
    @(posedge i_clk); @(negedge i_clk);
    i_cmd_vld = 1'b0;
  endtask

  // Check the head word at the tracked address, then pop it
  task automatic drain_expect(input string tag, input logic [31:0] w);
    chk({tag, "_wren"}, 32'(o_imem_wren), 32'd1);
    chk({tag, "_data"}, o_imem_wdata, w);
    chk({tag, "_addr"}, 32'(o_imem_addr), 32'(exp_addr));
    i_imem_rdy = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_imem_rdy = 1'b0;
    exp_addr = exp_addr + 12'd4;
  endtask

  task automatic exp_reject(input string tag, input logic [1:0] code);
    exp_cnt = exp_cnt + 8'd1;
    chk({tag, "_err"},  32'(o_err), 32'd1);
    chk({tag, "_code"}, 32'(o_err_code), 32'(code));
    chk({tag, "_cnt"},  32'(o_err_cnt), 32'(exp_cnt));
    chk({tag, "_nowr"}, 32'(o_imem_wren), 32'd0);
  endtask

  initial begin
    logic acc;
    n_vec = 0; n_err = 0; exp_addr = 12'd0; exp_cnt = 8'd0;
    i_reset = 1'b1; i_cmd_vld = 1'b0; i_addr_load = 1'b0; i_start_addr = 12'd0;
    i_imem_rdy = 1'b0;
    set_cmd(7'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge i_clk);
    chk("rst_wren",  32'(o_imem_wren), 32'd0);
    chk("rst_rdy",   32'(o_cmd_rdy), 32'd1);
    chk("rst_addr",  32'(o_imem_addr), 32'd0);
    chk("rst_wdata", o_imem_wdata, 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    chk("rst_code",  32'(o_err_code), 32'd0);
    chk("rst_cnt",   32'(o_err_cnt), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Basic encodings
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain_expect("addi", 32'h00500093);
    send(REG, 3'b000, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    drain_expect("sub", 32'h402081B3);
    send(BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8);
    drain_expect("beq", 32'hFE208CE3);
    send(JAL, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    drain_expect("jal", 32'h001000EF);
    send(BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    exp_reject("beq_odd", 2'b11);
    @(negedge i_clk);
    chk("err_pulse_end", 32'(o_err), 32'd0);
    chk("err_code_hold", 32'(o_err_code), 32'd3);

    send(REG, 3'b000, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0);
`ifdef RV32M_EN
    drain_expect("mul", 32'h027302B3);
`else
    exp_reject("mul", 2'b01);
`endif
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
    exp_reject("addi_2048", 2'b10);
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048);
    drain_expect("addi_m2048", 32'h80000093);
    send(IMM, 3'b001, 1'b0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32);
    exp_reject("slli_32", 2'b10);
    send(IMM, 3'b001, 1'b0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd31);
    drain_expect("slli_31", 32'h01F09093);
    send(IMM, 3'b101, 1'b1, 1'b0, 5'd2, 5'd3, 5'd0, 32'd4);
    drain_expect("srai", 32'h4041D113);
    send(IMM, 3'b001, 1'b1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd3);
    exp_reject("slli_f75", 2'b01);
    send(LUI, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    drain_expect("lui", 32'h123452B7);
    send(LUI, 3'b000, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345001);
    exp_reject("lui_low", 2'b11);
    send(STORE, 3'b010, 1'b0, 1'b0, 5'd0, 5'd2, 5'd5, -32'sd4);
    drain_expect("sw", 32'hFE512E23);
    send(7'h7F, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    exp_reject("bad_op", 2'b01);
    send(7'b0010000, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    exp_reject("bad_low", 2'b01);
    send(BR, 3'b010, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    exp_reject("br_f3", 2'b01);
    send(BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4097);
    exp_reject("br_prio", 2'b11);
    send(BR, 3'b000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096);
    exp_reject("br_rng", 2'b10);
    send(LOAD, 3'b011, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    exp_reject("ld_prio", 2'b01);
    send(JAL, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1048576);
    exp_reject("jal_rng", 2'b10);

    // Backpressure: fill, offer a fifth, then drain at full rate
    for (int k = 0; k < 4; k++)
      send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k + 1));
    chk("full_rdy", 32'(o_cmd_rdy), 32'd0);
    set_cmd(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    i_cmd_vld = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("stall_data", o_imem_wdata, 32'h00100093);
    chk("stall_addr", 32'(o_imem_addr), 32'(exp_addr));
    chk("stall_rdy",  32'(o_cmd_rdy), 32'd0);
    i_imem_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("burst_wren", 32'(o_imem_wren), 32'd1);
      chk("burst_data", o_imem_wdata, {12'(k + 1), 20'h00093});
      chk("burst_addr", 32'(o_imem_addr), 32'(exp_addr));
      acc = i_cmd_vld && o_cmd_rdy;
      @(posedge i_clk); @(negedge i_clk);
      if (acc) i_cmd_vld = 1'b0;
      exp_addr = exp_addr + 12'd4;
    end
    i_imem_rdy = 1'b0;
    chk("burst_empty", 32'(o_imem_wren), 32'd0);

    // Start address load with wrap past the top of memory
    i_start_addr = 12'hFFF; i_addr_load = 1'b1;
    @(negedge i_clk);
    i_addr_load = 1'b0;
    exp_addr = 12'hFFC;
    chk("load_addr", 32'(o_imem_addr), 32'h0FFC);
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    drain_expect("wrap0", 32'h00700093);
    chk("wrap_addr", 32'(o_imem_addr), 32'd0);
    drain_expect("wrap1", 32'h00800093);

    // Load while non-empty is ignored
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd10);
    i_start_addr = 12'h100; i_addr_load = 1'b1;
    @(negedge i_clk);
    i_addr_load = 1'b0;
    chk("load_ignored", 32'(o_imem_addr), 32'(exp_addr));
    drain_expect("after_ign", 32'h00A00093);

    // Reset with words buffered
    for (int k = 0; k < 3; k++)
      send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k + 1));
    chk("pre_rst_wren", 32'(o_imem_wren), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("async_wren",  32'(o_imem_wren), 32'd0);
    chk("async_addr",  32'(o_imem_addr), 32'd0);
    chk("async_rdy",   32'(o_cmd_rdy), 32'd1);
    chk("async_wdata", o_imem_wdata, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_addr = 12'd0; exp_cnt = 8'd0;
    @(negedge i_clk);
    chk("rst_cnt_clr", 32'(o_err_cnt), 32'd0);
    send(IMM, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd9);
    drain_expect("post_rst", 32'h00900093);
    chk("post_rst_empty", 32'(o_imem_wren), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
